// File: rtl/ktwt_cache_pipe.sv
// ---------------------------------------------------------------------------
// ktwt_cache_pipe
//
// Registered Kt+Wt adder for a SHA-256 style round pipeline, with optional
// shortcuts for message rounds whose schedule word is known ahead of time.
//
//   MODE 0 : ktwt = kt + wt for every round.
//   MODE 2 : second-block rounds 8..15 use fixed sums (padding block).
//   MODE 1 : first-block rounds 4..15 use fixed sums; rounds 16/17/19 depend
//            only on the message header, so they are computed once per header
//            (COLD -> FILL -> WARM) and replayed from cache for later nonces.
//            Round 19 carries the nonce, so its cached value is stepped by
//            NONCE_STEP on every warm pass.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  block enable; low freezes every register
//   flush      in   1  drop cached header values, return to COLD
//   in_valid   in   1  r_cntr/kt/wt valid this cycle
//   r_cntr     in   6  round index 0..63
//   kt         in   W  round constant
//   wt         in   W  schedule word
//   ktwt       out  W  registered round sum
//   out_valid  out  1  ktwt valid
//   cache_vld  out  1  FSM is in WARM
//   state_dbg  out  2  current FSM state (COLD=0, FILL=1, WARM=2)
//
// Handshake: there is no back-pressure. An input is accepted on a rising
// edge where en=1, in_valid=1 and flush=0; its result appears on ktwt with
// out_valid=1 after that same edge. An enabled edge without an accepted input
// (including flush) drops out_valid. A disabled edge changes nothing.
// ---------------------------------------------------------------------------
module ktwt_cache_pipe #(
    parameter int W          = 32,
    parameter int MODE       = 0,
    parameter int NONCE_STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [5:0]   r_cntr,
    input  logic [W-1:0] kt,
    input  logic [W-1:0] wt,
    output logic [W-1:0] ktwt,
    output logic         out_valid,
    output logic         cache_vld,
    output logic [1:0]   state_dbg
);

    generate
        if (((MODE == 1 || MODE == 2) && W != 32) || MODE > 2 || MODE < 0) begin : g_bad_param
            $error("ktwt_cache_pipe: MODE must be 0..2, and MODE 1/2 require W == 32");
        end
    endgenerate

    localparam logic [1:0] ST_COLD = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_WARM = 2'd2;

    // Fixed sums of Kt and the known padding/length words.
    localparam logic [W-1:0] K_M1_R4  = W'(32'hb956c25b);
    localparam logic [W-1:0] K_M1_R15 = W'(32'hc19bf3f4);
    localparam logic [W-1:0] K_M2_R8  = W'(32'h5807aa98);
    localparam logic [W-1:0] K_M2_R15 = W'(32'hc19bf274);
    // Header-dependent rounds: Kt plus the header part of the schedule word;
    // wt supplies the remaining (per-header) part.
    localparam logic [W-1:0] K_R16    = W'(32'he49b69c1);
    localparam logic [W-1:0] K_R17    = W'(32'hefbe4786);
    localparam logic [W-1:0] K_R19    = W'(32'h240ca1cc);
    localparam logic [W-1:0] STEP     = W'(NONCE_STEP);

    logic [1:0]   state;
    logic [1:0]   nxt_state;
    logic [W-1:0] c16, c17, c19;
    logic [W-1:0] nxt_c16, nxt_c17, nxt_c19;
    logic         got17;
    logic         nxt_got17;
    logic [W-1:0] sum;
    logic [W-1:0] res;
    logic         accept;
    logic         mid_round;

    assign accept    = in_valid & ~flush;
    assign sum       = kt + wt;
    assign mid_round = (r_cntr >= 6'd5) && (r_cntr <= 6'd14);

    // Result and next cache/FSM values for an accepted input. They are only
    // committed by the register block when the input is actually accepted.
    always_comb begin
        res       = sum;
        nxt_state = state;
        nxt_c16   = c16;
        nxt_c17   = c17;
        nxt_c19   = c19;
        nxt_got17 = got17;

        if (MODE == 2) begin
            if (r_cntr == 6'd8) begin
                res = K_M2_R8;
            end else if (r_cntr >= 6'd9 && r_cntr <= 6'd14) begin
                res = kt;
            end else if (r_cntr == 6'd15) begin
                res = K_M2_R15;
            end
        end else if (MODE == 1) begin
            if (r_cntr == 6'd4) begin
                res = K_M1_R4;
            end else if (mid_round) begin
                res = kt;
            end else if (r_cntr == 6'd15) begin
                res = K_M1_R15;
            end else if (r_cntr == 6'd16) begin
                if (state == ST_WARM) begin
                    res = c16;
                end else begin
                    // COLD starts a fill; a repeated r16 in FILL restarts it.
                    res       = wt + K_R16;
                    nxt_c16   = wt + K_R16;
                    nxt_got17 = 1'b0;
                    nxt_state = ST_FILL;
                end
            end else if (r_cntr == 6'd17) begin
                if (state == ST_WARM) begin
                    res = c17;
                end else if (state == ST_FILL) begin
                    res       = wt + K_R17;
                    nxt_c17   = wt + K_R17;
                    nxt_got17 = 1'b1;
                end
            end else if (r_cntr == 6'd19) begin
                if (state == ST_WARM) begin
                    res     = c19 + STEP;
                    nxt_c19 = c19 + STEP;
                end else if (state == ST_FILL && got17) begin
                    res       = wt + K_R19;
                    nxt_c19   = wt + K_R19;
                    nxt_state = ST_WARM;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_COLD;
            c16       <= '0;
            c17       <= '0;
            c19       <= '0;
            got17     <= 1'b0;
            ktwt      <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            if (flush) begin
                state     <= ST_COLD;
                c16       <= '0;
                c17       <= '0;
                c19       <= '0;
                got17     <= 1'b0;
                out_valid <= 1'b0;
            end else if (accept) begin
                state     <= nxt_state;
                c16       <= nxt_c16;
                c17       <= nxt_c17;
                c19       <= nxt_c19;
                got17     <= nxt_got17;
                ktwt      <= res;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign cache_vld = (state == ST_WARM);
    assign state_dbg = state;

endmodule

// File: tb/tb_ktwt_cache_pipe.sv
module tb_ktwt_cache_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, flush, in_valid;
    logic [5:0]  r_cntr;
    logic [31:0] kt, wt;

    logic [31:0] ktwt0, ktwt1, ktwt2;
    logic        ov0, ov1, ov2;
    logic        cv0, cv1, cv2;
    logic [1:0]  sd0, sd1, sd2;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected per enabled edge: {valid, data}
    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] exp_q2[$];
    logic [32:0] last0, last1, last2;

    // Reference model state for the MODE 1 header cache
    logic        m_warm, m_fill, m_have17;
    logic [31:0] m_c16, m_c17, m_c19;
    logic        exp_cv1;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    ktwt_cache_pipe #(.W(32), .MODE(0), .NONCE_STEP(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
        .r_cntr(r_cntr), .kt(kt), .wt(wt), .ktwt(ktwt0), .out_valid(ov0),
        .cache_vld(cv0), .state_dbg(sd0));
    ktwt_cache_pipe #(.W(32), .MODE(1), .NONCE_STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
        .r_cntr(r_cntr), .kt(kt), .wt(wt), .ktwt(ktwt1), .out_valid(ov1),
        .cache_vld(cv1), .state_dbg(sd1));
    ktwt_cache_pipe #(.W(32), .MODE(2), .NONCE_STEP(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
        .r_cntr(r_cntr), .kt(kt), .wt(wt), .ktwt(ktwt2), .out_valid(ov2),
        .cache_vld(cv2), .state_dbg(sd2));

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [33:0] act, input logic [33:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Data is only meaningful while valid is high.
    task automatic cmp_out(input string nm, input logic ov, input logic [31:0] d, input logic [32:0] e);
        check(nm, {1'b0, ov, ov ? d : 32'h0}, {1'b0, e[32], e[32] ? e[31:0] : 32'h0});
    endtask

    task automatic model_clear();
        m_warm = 0; m_fill = 0; m_have17 = 0;
        m_c16 = 0; m_c17 = 0; m_c19 = 0;
        exp_cv1 = 0;
    endtask

    // ---------------- driver ----------------
    // sel: 0 = model only, 1 = literal expectation for MODE 0, 2 = for MODE 1
    task automatic issue(input logic e, input logic f, input logic v, input logic [5:0] r,
                         input logic [31:0] k, input logic [31:0] w,
                         input int sel, input logic [31:0] lit);
        logic [31:0] e0, e1, e2;
        @(posedge clk);
        #1;
        en = e; flush = f; in_valid = v; r_cntr = r; kt = k; wt = w;
        if (e) begin
            if (f) begin
                model_clear();
                exp_q0.push_back(33'h0); exp_q1.push_back(33'h0); exp_q2.push_back(33'h0);
            end else if (!v) begin
                exp_q0.push_back(33'h0); exp_q1.push_back(33'h0); exp_q2.push_back(33'h0);
            end else begin
                e0 = k + w;
                e2 = k + w;
                if (r == 8) e2 = 32'h5807aa98;
                else if (r >= 9 && r <= 14) e2 = k;
                else if (r == 15) e2 = 32'hc19bf274;
                e1 = k + w;
                if (r == 4) e1 = 32'hb956c25b;
                else if (r >= 5 && r <= 14) e1 = k;
                else if (r == 15) e1 = 32'hc19bf3f4;
                else if (r == 16) begin
                    if (m_warm) e1 = m_c16;
                    else begin
                        e1 = w + 32'he49b69c1; m_c16 = e1; m_fill = 1; m_have17 = 0;
                    end
                end else if (r == 17) begin
                    if (m_warm) e1 = m_c17;
                    else if (m_fill) begin
                        e1 = w + 32'hefbe4786; m_c17 = e1; m_have17 = 1;
                    end
                end else if (r == 19) begin
                    if (m_warm) begin
                        m_c19 = m_c19 + 32'd1; e1 = m_c19;
                    end else if (m_fill && m_have17) begin
                        e1 = w + 32'h240ca1cc; m_c19 = e1; m_warm = 1; m_fill = 0;
                    end
                end
                if (sel == 1) e0 = lit;
                if (sel == 2) e1 = lit;
                exp_q0.push_back({1'b1, e0});
                exp_q1.push_back({1'b1, e1});
                exp_q2.push_back({1'b1, e2});
            end
        end
        exp_cv1 = m_warm;
    endtask

    task automatic do_reset_check(input string nm);
        check({nm, "_m0"}, {1'b0, ktwt0, ov0}, 34'h0);
        check({nm, "_m1"}, {ktwt1, ov1, cv1}, 34'h0);
        check({nm, "_m2"}, {1'b0, ktwt2, ov2}, 34'h0);
    endtask

    // Asserts reset between edges once the last issued input has been checked.
    task automatic reset_mid();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 0; en = 0; in_valid = 0; flush = 0;
        #1;
        do_reset_check("reset_mid");
        model_clear();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic en_s, rst_s, cv_s;
    logic [32:0] pe;

    initial begin
        last0 = 0; last1 = 0; last2 = 0;
        forever begin
            @(posedge clk);
            en_s = en; rst_s = rst_n; cv_s = exp_cv1;
            @(negedge clk);
            if (!rst_s) begin
                last0 = 0; last1 = 0; last2 = 0;
            end else begin
                if (en_s) begin
                    if (exp_q0.size() == 0 || exp_q1.size() == 0 || exp_q2.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL underflow: got output edge expected queued entry");
                    end else begin
                        pe = exp_q0.pop_front(); cmp_out("out_m0", ov0, ktwt0, pe); last0 = pe;
                        pe = exp_q1.pop_front(); cmp_out("out_m1", ov1, ktwt1, pe); last1 = pe;
                        pe = exp_q2.pop_front(); cmp_out("out_m2", ov2, ktwt2, pe); last2 = pe;
                    end
                end else begin
                    cmp_out("hold_m0", ov0, ktwt0, last0);
                    cmp_out("hold_m1", ov1, ktwt1, last1);
                    cmp_out("hold_m2", ov2, ktwt2, last2);
                end
                check("cache_vld_m1", {33'h0, cv1}, {33'h0, cv_s});
                check("cache_vld_m0m2", {32'h0, cv0, cv2}, 34'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] rr;
        en = 0; flush = 0; in_valid = 0; r_cntr = 0; kt = 0; wt = 0;
        model_clear();
        rst_n = 1;
        #1 rst_n = 0;
        #2 do_reset_check("reset_init");
        repeat (2) @(negedge clk);
        #2 rst_n = 1;

        // plain Kt+Wt on round 0
        issue(1, 0, 1, 6'd0, 32'h428a2f98, 32'h61626380, 1, 32'ha3ec9318);

        // cold nonce
        issue(1, 0, 1, 6'd16, $urandom, 32'd0, 2, 32'he49b69c1);
        issue(1, 0, 1, 6'd17, $urandom, 32'd1, 2, 32'hefbe4787);
        issue(1, 0, 1, 6'd19, $urandom, 32'd2, 2, 32'h240ca1ce);

        // warm replays
        issue(1, 0, 1, 6'd19, $urandom, $urandom, 2, 32'h240ca1cf);
        issue(1, 0, 1, 6'd19, $urandom, $urandom, 2, 32'h240ca1d0);
        issue(1, 0, 1, 6'd16, $urandom, $urandom, 2, 32'he49b69c1);
        issue(1, 0, 1, 6'd17, $urandom, $urandom, 2, 32'hefbe4787);

        // disabled edges hold everything
        issue(0, 0, 1, 6'd19, $urandom, $urandom, 0, 0);
        issue(0, 1, 1, 6'd16, $urandom, $urandom, 0, 0);

        // walk all fixed-sum rounds and beyond
        for (int r = 0; r < 24; r++)
            issue(1, 0, 1, 6'(r), $urandom, $urandom, 0, 0);

        // flush beats a simultaneous r16 in WARM, then restart the fill
        issue(1, 1, 1, 6'd16, $urandom, $urandom, 0, 0);
        issue(1, 0, 1, 6'd16, $urandom, 32'd5, 2, 32'he49b69c6);

        // wrap of the cached nonce word
        issue(1, 0, 1, 6'd17, $urandom, $urandom, 0, 0);
        issue(1, 0, 1, 6'd19, $urandom, 32'hdbf35e33, 2, 32'hffffffff);
        issue(1, 0, 1, 6'd19, $urandom, $urandom, 2, 32'h00000000);

        // r19 in FILL without r17 stays in FILL; repeated r16 restarts it
        issue(1, 1, 0, 6'd0, 0, 0, 0, 0);
        issue(1, 0, 1, 6'd16, $urandom, $urandom, 0, 0);
        issue(1, 0, 1, 6'd19, $urandom, $urandom, 0, 0);
        issue(1, 0, 1, 6'd17, $urandom, $urandom, 0, 0);
        issue(1, 0, 1, 6'd16, $urandom, $urandom, 0, 0);
        issue(1, 0, 1, 6'd19, $urandom, $urandom, 0, 0);
        issue(1, 0, 1, 6'd17, $urandom, $urandom, 0, 0);
        issue(1, 0, 1, 6'd19, $urandom, $urandom, 0, 0);

        // reset in the middle of a fill
        issue(1, 1, 0, 6'd0, 0, 0, 0, 0);
        issue(1, 0, 1, 6'd16, $urandom, $urandom, 0, 0);
        issue(1, 0, 1, 6'd17, $urandom, $urandom, 0, 0);
        reset_mid();
        issue(1, 0, 1, 6'd19, 32'h14292967, 32'h00000010, 2, 32'h14292977);
        issue(1, 0, 1, 6'd19, $urandom, $urandom, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rr = 6'($urandom_range(0, 63));
            else rr = 6'($urandom_range(14, 19));
            issue($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 3) != 0, rr, $urandom, $urandom, 0, 0);
        end

        // drain
        repeat (3) issue(0, 0, 0, 6'd0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("drain_q0", 34'(exp_q0.size()), 34'h0);
        check("drain_q1", 34'(exp_q1.size()), 34'h0);
        check("drain_q2", 34'(exp_q2.size()), 34'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
